plant_ctrl_array: RTL

//  NCH-channel parametrised plant controller, next generation of the single plant FSM in user_project_wrapper.

---
 rtl/plant_pkg.sv | 57 +++++
 rtl/plant_channel.sv | 204 ++++++++++++++++++++
 rtl/plant_ctrl_array.sv | 87 ++++++++
 3 files changed

// File: rtl/plant_pkg.sv
// -----------------------------------------------------------------------------
// plant_pkg
//   Shared types and io-field layout for the plant controller array.
//   - plant_state_e : per-channel controller state.
//   - FLD_*         : io field indices. Inputs use the first three, outputs the
//                     last three. Each field is NCH bits wide.
//   - *_base()      : first io bit of a field for a given channel count.
// -----------------------------------------------------------------------------
package plant_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      HOLD  = 3'd2,
      DONE  = 3'd3,
      FAULT = 3'd4
   } plant_state_e;

   // Inside a channel, the first three indices also select the bit of the
   // packed {fault, stop, start} input vector.
   localparam int FLD_START = 0;
   localparam int FLD_STOP  = 1;
   localparam int FLD_FAULT = 2;
   localparam int FLD_RUN   = 3;
   localparam int FLD_DONE  = 4;
   localparam int FLD_ALARM = 5;
   localparam int IO_FIELDS = 6;

   function automatic int field_base(input int nch, input int fld);
      return fld * nch;
   endfunction

   function automatic int start_base(input int nch);
      return field_base(nch, FLD_START);
   endfunction

   function automatic int stop_base(input int nch);
      return field_base(nch, FLD_STOP);
   endfunction

   function automatic int fault_base(input int nch);
      return field_base(nch, FLD_FAULT);
   endfunction

   function automatic int run_base(input int nch);
      return field_base(nch, FLD_RUN);
   endfunction

   function automatic int done_base(input int nch);
      return field_base(nch, FLD_DONE);
   endfunction

   function automatic int alarm_base(input int nch);
      return field_base(nch, FLD_ALARM);
   endfunction

endpackage

// File: rtl/plant_channel.sv
// -----------------------------------------------------------------------------
// plant_channel
//   One plant controller channel: 2-flop synchroniser and debounce filter on
//   start/stop/fault, then a run-timer FSM (IDLE/RUN/HOLD/DONE/FAULT).
//   Optional HOLD watchdog under macro PLANT_WATCHDOG_EN: HOLD_TO cycles in
//   HOLD force FAULT. Without the macro HOLD persists indefinitely.
// Ports
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   en_i     : channel enable (already combined with the global enable)
//   start_i  : raw asynchronous start (rising edge of filtered value acts)
//   stop_i   : raw asynchronous stop  (level)
//   fault_i  : raw asynchronous fault (level)
//   run_o    : state == RUN
//   done_o   : state == DONE
//   alarm_o  : state == FAULT
// -----------------------------------------------------------------------------
module plant_channel
   import plant_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int RUN_TICKS = 100,
   parameter int DEB_LEN   = 3,
   parameter int HOLD_TO   = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic start_i,
   input  logic stop_i,
   input  logic fault_i,
   output logic run_o,
   output logic done_o,
   output logic alarm_o
);

   localparam int               DEB_W    = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEB_LEN - 1);
   localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_TICKS - 1);

   if (DEB_LEN < 1) begin : g_bad_deb_len
      $error("plant_channel: DEB_LEN must be >= 1");
   end
   if ((RUN_TICKS < 1) || (RUN_TICKS >= (1 << CNT_W))) begin : g_bad_run_ticks
      $error("plant_channel: RUN_TICKS must be in 1..2**CNT_W-1");
   end
   if (HOLD_TO < 1) begin : g_bad_hold_to
      $error("plant_channel: HOLD_TO must be >= 1");
   end

   // ---------------------------------------------------------------- filter
   logic [2:0]       raw_in;
   logic [2:0]       sync1_q;
   logic [2:0]       sync2_q;
   logic [2:0]       filt_q;
   logic [DEB_W-1:0] deb_cnt_q [3];
   logic             start_prev_q;

   assign raw_in = {fault_i, stop_i, start_i};

   // The filtered value flips once DEB_LEN consecutive synchronised samples
   // disagree with it; any agreeing sample restarts the count.
   always_ff @(posedge clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values, whatever order the statements are in.
      if (!rst_ni) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         filt_q       <= '0;
         start_prev_q <= 1'b0;
         // NOTE: this small counter array is control state, not storage, so
         // it is reset like any other register; large data memories are not.
         for (int i = 0; i < 3; i++) begin
            deb_cnt_q[i] <= '0;
         end
      end else begin
         sync1_q      <= raw_in;
         sync2_q      <= sync1_q;
         start_prev_q <= filt_q[FLD_START];
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
               deb_cnt_q[i] <= '0;
            end else if (deb_cnt_q[i] == DEB_MAX) begin
               filt_q[i]    <= sync2_q[i];
               deb_cnt_q[i] <= '0;
            end else begin
               deb_cnt_q[i] <= deb_cnt_q[i] + DEB_W'(1);
            end
         end
      end
   end

   logic start_edge;
   logic start_lvl;
   logic stop_lvl;
   logic fault_lvl;

   assign start_lvl  = filt_q[FLD_START];
   assign stop_lvl   = filt_q[FLD_STOP];
   assign fault_lvl  = filt_q[FLD_FAULT];
   assign start_edge = start_lvl & ~start_prev_q;

   // ------------------------------------------------------------------- FSM
   plant_state_e     state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;

`ifdef PLANT_WATCHDOG_EN
   localparam int                HOLD_W   = (HOLD_TO > 1) ? $clog2(HOLD_TO) : 1;
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_TO - 1);
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         timer_q    <= '0;
`ifdef PLANT_WATCHDOG_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
`ifdef PLANT_WATCHDOG_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so that no path
      // leaves it unassigned, which would infer a latch.
      state_d    = state_q;
      timer_d    = timer_q;
`ifdef PLANT_WATCHDOG_EN
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (start_edge && en_i) begin
               state_d = RUN;
               timer_d = RUN_LOAD;
            end
         end
         RUN: begin
            if (fault_lvl) begin
               state_d = FAULT;
            end else if (!en_i) begin
               state_d = IDLE;
            end else if (stop_lvl) begin
               // The RUN cycle that sees stop still consumes its tick, so
               // RUN time before and after HOLD adds up to RUN_TICKS. The
               // timer saturates at 0 rather than wrapping.
               state_d = HOLD;
               timer_d = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);
`ifdef PLANT_WATCHDOG_EN
               hold_cnt_d = '0;
`endif
            end else if (timer_q == '0) begin
               state_d = DONE;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (fault_lvl) begin
               state_d = FAULT;
            end else if (!en_i) begin
               state_d = IDLE;
            end else if (start_edge && !stop_lvl) begin
               state_d = RUN;
            end
`ifdef PLANT_WATCHDOG_EN
            else if (hold_cnt_q == HOLD_MAX) begin
               state_d = FAULT;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
`else
            // No watchdog: HOLD waits for start, disable or fault.
`endif
         end
         DONE: begin
            if (fault_lvl) begin
               state_d = FAULT;
            end else if (!start_lvl) begin
               state_d = IDLE;
            end
         end
         FAULT: begin
            // Sticky and independent of enable; needs an explicit stop once
            // the fault has cleared.
            if (!fault_lvl && stop_lvl) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign run_o   = (state_q == RUN);
   assign done_o  = (state_q == DONE);
   assign alarm_o = (state_q == FAULT);

endmodule

// File: rtl/plant_ctrl_array.sv
// -----------------------------------------------------------------------------
// plant_ctrl_array
//   NCH independent plant controller channels mapped onto the io bus.
//   Optional HOLD watchdog in every channel under macro PLANT_WATCHDOG_EN.
// Ports
//   wb_clk_i : clock
//   wb_rst_i : synchronous active-low reset
//   wbs_we_i : global enable, ANDed with every chan_en bit
//   chan_en  : per-channel enable
//   io_in    : [ch]=start, [NCH+ch]=stop, [2NCH+ch]=fault
//   io_out   : [3NCH+ch]=run, [4NCH+ch]=done, [5NCH+ch]=alarm, others 0
//   io_oeb   : constant; outputs enabled (0) on [6NCH-1:3NCH] only
// -----------------------------------------------------------------------------
module plant_ctrl_array
   import plant_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int IO_W      = 38,
   parameter int CNT_W     = 8,
   parameter int RUN_TICKS = 100,
   parameter int DEB_LEN   = 3,
   parameter int HOLD_TO   = 64
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic            wbs_we_i,
   input  logic [NCH-1:0]  chan_en,
   input  logic [IO_W-1:0] io_in,
   output logic [IO_W-1:0] io_out,
   output logic [IO_W-1:0] io_oeb
);

   localparam int START_B = start_base(NCH);
   localparam int STOP_B  = stop_base(NCH);
   localparam int FAULT_B = fault_base(NCH);
   localparam int RUN_B   = run_base(NCH);
   localparam int DONE_B  = done_base(NCH);
   localparam int ALARM_B = alarm_base(NCH);
   localparam int USED_W  = IO_FIELDS * NCH;

   if (USED_W > IO_W) begin : g_bad_io_w
      $error("plant_ctrl_array: 6*NCH must not exceed IO_W");
   end

   logic [NCH-1:0] run;
   logic [NCH-1:0] done;
   logic [NCH-1:0] alarm;

   for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
      plant_channel #(
         .CNT_W     (CNT_W),
         .RUN_TICKS (RUN_TICKS),
         .DEB_LEN   (DEB_LEN),
         .HOLD_TO   (HOLD_TO)
      ) u_chan (
         .clk_i   (wb_clk_i),
         .rst_ni  (wb_rst_i),
         .en_i    (chan_en[ch] & wbs_we_i),
         .start_i (io_in[START_B+ch]),
         .stop_i  (io_in[STOP_B+ch]),
         .fault_i (io_in[FAULT_B+ch]),
         .run_o   (run[ch]),
         .done_o  (done[ch]),
         .alarm_o (alarm[ch])
      );
   end

   always_comb begin
      io_out = '0;
      for (int ch = 0; ch < NCH; ch++) begin
         io_out[RUN_B+ch]   = run[ch];
         io_out[DONE_B+ch]  = done[ch];
         io_out[ALARM_B+ch] = alarm[ch];
      end
   end

   // Input field bits drive inputs (1), output field bits drive out (0),
   // the unused upper bits stay as inputs.
   for (genvar i = 0; i < IO_W; i++) begin : g_oeb
      assign io_oeb[i] = (i < RUN_B) || (i >= USED_W);
   end

   // Pins above the input fields are not inputs of this block.
   logic unused_io_in;
   assign unused_io_in = ^io_in[IO_W-1:RUN_B];

endmodule
